// File: rtl/enc_pkg.sv
// Shared constants, FSM encoding and rotate helper for the 8-to-3 sequential encoder.
// Optional round-robin selection is enabled by defining ENC_RR_EN.
package enc_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_t;

  // Rotate right so that bit 'sh' lands on bit 0; bit sh-1 then sits at the top.
  function automatic logic [N_REQ-1:0] rot_right(input logic [N_REQ-1:0] v,
                                                 input logic [IDX_W-1:0] sh);
    logic [2*N_REQ-1:0] d;
    d = {v, v} >> sh;
    return d[N_REQ-1:0];
  endfunction

endpackage

// File: rtl/pri_enc_8x3.sv
// Combinational highest-set-bit encoder: bit 7 wins, zero flags an empty request vector.
module pri_enc_8x3
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  always_comb begin
    idx  = '0;
    zero = (req == '0);
    // Ascending scan so the last (highest) set bit overwrites lower ones.
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/enc_8x3_seq.sv
// Sequential 8-to-3 request encoder: accumulates requests and presents one index per cycle.
// Define ENC_RR_EN for round-robin selection; default is fixed priority (bit 7 highest).
module enc_8x3_seq
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] in,
  input  logic             E,
  input  logic             ready,
  output logic [IDX_W-1:0] out,
  output logic             valid,
  output logic             empty
);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] pending, pending_nxt;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] out_nxt;
  logic [IDX_W-1:0] enc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             enc_zero;
  logic             sel;

`ifdef ENC_RR_EN
  logic [IDX_W-1:0] ptr;

  // Rotating by ptr puts index ptr-1 at the top, so the encoder searches
  // ptr-1 downward with wrap; adding ptr back recovers the real index.
  assign cand    = rot_right(pending, ptr);
  assign sel_idx = enc_idx + ptr;

  always_ff @(posedge clk) begin
    if (rst)      ptr <= '0;
    else if (sel) ptr <= sel_idx;
  end
`else
  assign cand    = pending;
  assign sel_idx = enc_idx;
`endif

  pri_enc_8x3 u_enc (
    .req  (cand),
    .idx  (enc_idx),
    .zero (enc_zero)
  );

  always_comb begin
    state_nxt = state;
    out_nxt   = out;
    sel       = 1'b0;
    clr       = '0;
    case (state)
      IDLE: begin
        if (!enc_zero) begin
          sel       = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (ready) begin
          if (!enc_zero) sel = 1'b1;
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (sel) begin
      out_nxt = sel_idx;
      clr     = N_REQ'(1) << sel_idx;
    end
    // New requests are OR-ed in after the clear, so a re-assert of the granted bit survives.
    pending_nxt = (pending & ~clr) | (E ? in : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      out     <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      out     <= out_nxt;
    end
  end

  assign valid = (state == OUT);
  assign empty = (pending == '0) && !valid;

endmodule
